// File: rtl/hazard_pkg.sv
// Shared encodings, timing constants and the per-stage writer record for the
// hazard scoreboard of the 5-stage MIPS pipeline.
package hazard_pkg;

    localparam int REC_REG_W = 5;
    localparam int REC_T_W   = 4;

    // D-stage source selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    // E-stage operand selects
    localparam logic [1:0] EFWD_REG = 2'b00;
    localparam logic [1:0] EFWD_M   = 2'b01;
    localparam logic [1:0] EFWD_W   = 2'b10;

    localparam logic [REC_T_W-1:0] TUSE_NONE = 4'd10;
    localparam logic [REC_T_W-1:0] TNEW_LINK = 4'd0;
    localparam logic [REC_T_W-1:0] TNEW_ALU  = 4'd1;
    localparam logic [REC_T_W-1:0] TNEW_LOAD = 4'd2;

    typedef struct packed {
        logic [REC_REG_W-1:0] wreg;
        logic [REC_T_W-1:0]   tnew;
    } stage_rec;

    // tnew ages by one per stage but never wraps below zero
    function automatic logic [REC_T_W-1:0] sat_dec(input logic [REC_T_W-1:0] t);
        return (t == '0) ? '0 : t - {{(REC_T_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Resolves one D-stage source register against the E/M/W writer records:
// newest matching stage decides both the stall request and the D forward select.
module hazard_match
    import hazard_pkg::*;
(
    input  logic [REC_REG_W-1:0] r,
    input  logic [REC_T_W-1:0]   tuse,
    input  stage_rec             e_rec,
    input  stage_rec             m_rec,
    input  logic [REC_REG_W-1:0] w_wreg,
    output logic                 stall_req,
    output logic [1:0]           fwd_sel
);

    always_comb begin
        stall_req = 1'b0;
        fwd_sel   = FWD_RF;
        // register 0 is hardwired, so it never participates
        if (r != '0) begin
            if (e_rec.wreg == r) begin
                stall_req = (e_rec.tnew > tuse);
                if (e_rec.tnew == '0) fwd_sel = FWD_E;
            end else if (m_rec.wreg == r) begin
                stall_req = (m_rec.tnew > tuse);
                if (m_rec.tnew == '0) fwd_sel = FWD_M;
            end else if (w_wreg == r) begin
                fwd_sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Registered E/M/W writer records with tnew ageing, D-stage stall and D/E forward
// selects. Define HAZ_STALL_CNT_EN to add the stall_cnt event counter port.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int T_W   = 4
`ifdef HAZ_STALL_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [T_W-1:0]   d_tuse,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic [REG_W-1:0] d_wreg,
    input  logic [T_W-1:0]   d_tnew,
    output logic             stall,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_rs,
    output logic [1:0]       fwd_e_rt,
    output logic [REG_W-1:0] e_wreg,
    output logic [REG_W-1:0] m_wreg,
    output logic [REG_W-1:0] w_wreg
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    logic [REG_W-1:0] e_rs;
    logic [REG_W-1:0] e_rt;
    stage_rec         e_rec;
    stage_rec         m_rec;
    logic [REG_W-1:0] w_wreg_q;
    logic             stall_rs;
    logic             stall_rt;

    // M and W always advance; only E takes a bubble when D is held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_rs     <= '0;
            e_rt     <= '0;
            e_rec    <= '0;
            m_rec    <= '0;
            w_wreg_q <= '0;
        end else begin
            w_wreg_q   <= m_rec.wreg;
            m_rec.wreg <= e_rec.wreg;
            m_rec.tnew <= sat_dec(e_rec.tnew);
            if (stall) begin
                e_rs  <= '0;
                e_rt  <= '0;
                e_rec <= '0;
            end else begin
                e_rs       <= d_rs;
                e_rt       <= d_rt;
                e_rec.wreg <= d_wreg;
                e_rec.tnew <= d_tnew;
            end
        end
    end

    hazard_match u_match_rs (
        .r         (d_rs),
        .tuse      (d_tuse),
        .e_rec     (e_rec),
        .m_rec     (m_rec),
        .w_wreg    (w_wreg_q),
        .stall_req (stall_rs),
        .fwd_sel   (fwd_d_rs)
    );

    hazard_match u_match_rt (
        .r         (d_rt),
        .tuse      (d_tuse),
        .e_rec     (e_rec),
        .m_rec     (m_rec),
        .w_wreg    (w_wreg_q),
        .stall_req (stall_rt),
        .fwd_sel   (fwd_d_rt)
    );

    assign stall = stall_rs | stall_rt;

    // A matching M writer with tnew > 0 is excluded by the stall, so only tnew == 0 forwards
    function automatic logic [1:0] efwd_sel(input logic [REG_W-1:0] r);
        logic [1:0] sel;
        sel = EFWD_REG;
        if (r != '0) begin
            if (m_rec.wreg == r && m_rec.tnew == '0) sel = EFWD_M;
            else if (w_wreg_q == r)                  sel = EFWD_W;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_e_rs = efwd_sel(e_rs);
        fwd_e_rt = efwd_sel(e_rt);
    end

    assign e_wreg = e_rec.wreg;
    assign m_wreg = m_rec.wreg;
    assign w_wreg = w_wreg_q;

`ifdef HAZ_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  stall_cnt <= '0;
        else if (stall) stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard: the driver pushes hand-computed
// expected outputs per cycle, a monitor pops and compares on the falling edge.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int W = 24;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] d_tuse = TUSE_NONE;
    logic [4:0] d_rs = '0;
    logic [4:0] d_rt = '0;
    logic [4:0] d_wreg = 5'd5;
    logic [3:0] d_tnew = TNEW_ALU;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic [4:0] e_wreg, m_wreg, w_wreg;
`ifdef HAZ_STALL_CNT_EN
    logic [1:0] stall_cnt;
`endif

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           errors = 0;
    int           checks = 0;

    // ---------------- clock / reset
    always #5 clk = ~clk;

`ifdef HAZ_STALL_CNT_EN
    hazard_scoreboard #(.REG_W(5), .T_W(4), .CNT_W(2)) dut (
`else
    hazard_scoreboard #(.REG_W(5), .T_W(4)) dut (
`endif
        .clk      (clk),
        .reset_n  (reset_n),
        .d_tuse   (d_tuse),
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_wreg   (d_wreg),
        .d_tnew   (d_tnew),
        .stall    (stall),
        .fwd_d_rs (fwd_d_rs),
        .fwd_d_rt (fwd_d_rt),
        .fwd_e_rs (fwd_e_rs),
        .fwd_e_rt (fwd_e_rt),
        .e_wreg   (e_wreg),
        .m_wreg   (m_wreg),
        .w_wreg   (w_wreg)
`ifdef HAZ_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // ---------------- driver
    // One pipeline cycle: apply reset and D inputs just after the edge, and queue
    // the outputs expected for this cycle {stall, fdrs, fdrt, fers, fert, e, m, w}.
    task automatic cyc(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wr, input logic [3:0] tn, input logic [3:0] tu,
                       input string nm, input logic st,
                       input logic [1:0] fdrs, input logic [1:0] fdrt,
                       input logic [1:0] fers, input logic [1:0] fert,
                       input logic [4:0] ew, input logic [4:0] mw, input logic [4:0] ww);
        @(posedge clk);
        #1;
        reset_n = rst;
        d_rs    = rs;
        d_rt    = rt;
        d_wreg  = wr;
        d_tnew  = tn;
        d_tuse  = tu;
        exp_q.push_back({st, fdrs, fdrt, fers, fert, ew, mw, ww});
        name_q.push_back(nm);
    endtask

    task automatic nop(input string nm, input logic [1:0] fers, input logic [1:0] fert,
                       input logic [4:0] ew, input logic [4:0] mw, input logic [4:0] ww);
        cyc(1'b1, 5'd0, 5'd0, 5'd0, TNEW_LINK, TUSE_NONE, nm, 1'b0,
            2'b00, 2'b00, fers, fert, ew, mw, ww);
    endtask

    // lw r8 followed by a dependent ALU op; leaves the pipe empty again
    task automatic load_use_pair();
        cyc(1'b1, 5'd0, 5'd0, 5'd8, TNEW_LOAD, TUSE_NONE, "lup_lw",    1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
        cyc(1'b1, 5'd8, 5'd0, 5'd0, TNEW_ALU,  TNEW_ALU,  "lup_stall", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd8, 5'd0, 5'd0);
        cyc(1'b1, 5'd8, 5'd0, 5'd0, TNEW_ALU,  TNEW_ALU,  "lup_go",    1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd8, 5'd0);
        nop("lup_efwd_w", 2'b10, 2'b00, 5'd0, 5'd0, 5'd8);
        nop("lup_drain",  2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    // ---------------- scoreboard monitor
    logic [W-1:0] act;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            act = {stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, e_wreg, m_wreg, w_wreg};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got st=%b fd=%b/%b fe=%b/%b e=%0d m=%0d w=%0d, want st=%b fd=%b/%b fe=%b/%b e=%0d m=%0d w=%0d",
                         n, act[23], act[22:21], act[20:19], act[18:17], act[16:15],
                         act[14:10], act[9:5], act[4:0],
                         e[23], e[22:21], e[20:19], e[18:17], e[16:15],
                         e[14:10], e[9:5], e[4:0]);
            end
        end
    end

    // ---------------- stimulus
    initial begin
        // reset held with a pending writer on the D inputs
        cyc(1'b0, 5'd0, 5'd0, 5'd5, TNEW_ALU, TUSE_NONE, "rst_hold0", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
        cyc(1'b0, 5'd0, 5'd0, 5'd5, TNEW_ALU, TUSE_NONE, "rst_hold1", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
        cyc(1'b1, 5'd0, 5'd0, 5'd5, TNEW_ALU, TUSE_NONE, "rst_rel",   1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
        nop("first_load_e", 2'b00, 2'b00, 5'd5, 5'd0, 5'd0);
        nop("advance_m",    2'b00, 2'b00, 5'd0, 5'd5, 5'd0);
        nop("advance_w",    2'b00, 2'b00, 5'd0, 5'd0, 5'd5);

        // load-use: lw r8 then addu r10 <- r8, r9
        cyc(1'b1, 5'd2, 5'd0, 5'd8,  TNEW_LOAD, TNEW_ALU, "lw_issue",   1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
        cyc(1'b1, 5'd8, 5'd9, 5'd10, TNEW_ALU,  TNEW_ALU, "lu_stall",   1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd8, 5'd0, 5'd0);
        cyc(1'b1, 5'd8, 5'd9, 5'd10, TNEW_ALU,  TNEW_ALU, "lu_release", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd8, 5'd0);
        nop("lu_efwd_w", 2'b10, 2'b00, 5'd10, 5'd0, 5'd8);

        // addu r3 then beq on r3
        cyc(1'b1, 5'd0, 5'd0, 5'd3, TNEW_ALU,  TNEW_ALU,  "alu_issue",  1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd10, 5'd0);
        cyc(1'b1, 5'd3, 5'd0, 5'd0, TNEW_LINK, 4'd0,      "beq_stall",  1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd3, 5'd0, 5'd10);
        cyc(1'b1, 5'd3, 5'd0, 5'd0, TNEW_LINK, 4'd0,      "beq_fwd_m",  1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 5'd0, 5'd3, 5'd0);

        // jal r31 then jr r31
        cyc(1'b1, 5'd0,  5'd0, 5'd31, TNEW_LINK, TUSE_NONE, "jal_issue", 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 5'd0, 5'd0, 5'd3);
        cyc(1'b1, 5'd31, 5'd0, 5'd0,  TNEW_LINK, 4'd0,      "jr_fwd_e",  1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 5'd31, 5'd0, 5'd0);

        // two writes to r4, then a reader with rs == rt == 4
        cyc(1'b1, 5'd0, 5'd0, 5'd4, TNEW_ALU, TNEW_ALU, "wr4_a",     1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 5'd0, 5'd31, 5'd0);
        cyc(1'b1, 5'd0, 5'd0, 5'd4, TNEW_ALU, TNEW_ALU, "wr4_b",     1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd4, 5'd0, 5'd31);
        cyc(1'b1, 5'd4, 5'd4, 5'd5, TNEW_ALU, TNEW_ALU, "rd4_d",     1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd4, 5'd4, 5'd0);
        nop("rd4_e_newest_m", 2'b01, 2'b01, 5'd5, 5'd4, 5'd4);

        // writes to $0 never match
        cyc(1'b1, 5'd0, 5'd0, 5'd0, TNEW_ALU, TNEW_ALU, "wr0",       1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd5, 5'd4);
        cyc(1'b1, 5'd0, 5'd0, 5'd6, TNEW_ALU, 4'd0,     "rd0",       1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd5);

        // rt-side stall and forwarding
        cyc(1'b1, 5'd0, 5'd6, 5'd0, TNEW_LINK, 4'd0,    "rt_stall",  1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 5'd6, 5'd0, 5'd0);
        cyc(1'b1, 5'd0, 5'd6, 5'd0, TNEW_LINK, 4'd0,    "rt_fwd_m",  1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 5'd0, 5'd6, 5'd0);
        nop("rt_efwd_w", 2'b00, 2'b10, 5'd0, 5'd0, 5'd6);

        // D forward from W
        cyc(1'b1, 5'd0, 5'd0, 5'd7, TNEW_ALU, TUSE_NONE, "wr7",      1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
        nop("wr7_e", 2'b00, 2'b00, 5'd7, 5'd0, 5'd0);
        nop("wr7_m", 2'b00, 2'b00, 5'd0, 5'd7, 5'd0);
        cyc(1'b1, 5'd7, 5'd0, 5'd0, TNEW_LINK, 4'd0,     "fwd_d_w",  1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd7);

        // tuse none never stalls even behind a load
        cyc(1'b1, 5'd0,  5'd0, 5'd12, TNEW_LOAD, TUSE_NONE, "lw12",       1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
        cyc(1'b1, 5'd12, 5'd0, 5'd0,  TNEW_LINK, TUSE_NONE, "tuse_none",  1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd12, 5'd0, 5'd0);
        nop("m_tnew_nonzero", 2'b00, 2'b00, 5'd0, 5'd12, 5'd0);

        // reset mid-operation drops in-flight records at once
        cyc(1'b1, 5'd0, 5'd0, 5'd9, TNEW_ALU, TUSE_NONE, "pre_rst",  1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd12);
        cyc(1'b0, 5'd0, 5'd0, 5'd9, TNEW_ALU, TUSE_NONE, "mid_rst",  1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
        nop("post_rst", 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);

        for (int i = 0; i < 3; i++) load_use_pair();
`ifdef HAZ_STALL_CNT_EN
        @(negedge clk);
        checks++;
        if (stall_cnt !== 2'd3) begin
            errors++;
            $display("FAIL stall_cnt_three: got %0d want 3", stall_cnt);
        end
        load_use_pair();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 2'd0) begin
            errors++;
            $display("FAIL stall_cnt_wrap: got %0d want 0", stall_cnt);
        end
`endif

        // let the monitor drain the queue, bounded
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
